// File: rtl/mem_write_ctrl_pkg.sv
// rtl/mem_write_ctrl_pkg.sv - shared state encoding and defaults for the store write controller
package mem_write_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR1,
    WR2,
    DONE,
    ERR
  } wrState_t;

  localparam int DEFAULT_ADDR_STEP = 4;
  localparam int DEFAULT_MAX_WAIT  = 15;

endpackage

// File: rtl/mem_write_ctrl_ack_timer.sv
// rtl/mem_write_ctrl_ack_timer.sv - memAck wait counter; timeout flags the cycle the count would reach MAX_WAIT
module mem_ack_timer
  import mem_write_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(MAX_WAIT))) begin
      count <= count + CW'(1);
    end
  end

  // An ack in the final allowed cycle suppresses enable, so it still counts as success.
  assign timeout = enable && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_write_ctrl.sv
// rtl/mem_write_ctrl.sv - store execution stage: one/two-word memory write with held done flags
// Optional trace output guarded by MEMWR_TRACE_EN.
module mem_write_ctrl
  import mem_write_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = DEFAULT_ADDR_STEP,
  parameter int MAX_WAIT  = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              storeValid,
  output logic              storeReady,
  input  logic              storeDouble,
  input  logic [ADDR_W-1:0] storeAddr,
  input  logic [DATA_W-1:0] storeData1,
  input  logic [DATA_W-1:0] storeData2,
  input  logic              noStore,
  input  logic              instrClear,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic              memAck,
  output logic              memWriteDone1,
  output logic              memWriteDone2,
  output logic              memWriteErr
);

  wrState_t          state, stateNext;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] data1Q, data2Q;
  logic              doubleQ;
  logic              ackHit, expired;

  assign ackHit = memReq && memAck;

  mem_ack_timer #(.MAX_WAIT(MAX_WAIT)) ackTimer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!memReq),
    .enable (memReq && !memAck),
    .timeout(expired)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (storeReady && storeValid)  stateNext = WR1;
        else if (storeReady && noStore) stateNext = DONE;
      end
      WR1: begin
        if (ackHit)       stateNext = doubleQ ? WR2 : DONE;
        else if (expired) stateNext = ERR;
      end
      WR2: begin
        if (ackHit)       stateNext = DONE;
        else if (expired) stateNext = ERR;
      end
      DONE, ERR: begin
        if (instrClear) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      storeReady    <= 1'b0;
      memReq        <= 1'b0;
      memAddr       <= '0;
      memWData      <= '0;
      memWriteDone1 <= 1'b0;
      memWriteDone2 <= 1'b0;
      memWriteErr   <= 1'b0;
      addrQ         <= '0;
      data1Q        <= '0;
      data2Q        <= '0;
      doubleQ       <= 1'b0;
    end else begin
      state      <= stateNext;
      storeReady <= (stateNext == IDLE);
      case (state)
        IDLE: begin
          if (storeReady && storeValid) begin
            addrQ   <= storeAddr;
            data1Q  <= storeData1;
            data2Q  <= storeData2;
            doubleQ <= storeDouble;
          end else if (storeReady && noStore) begin
            memWriteDone1 <= 1'b1;
            memWriteDone2 <= 1'b1;
          end
        end
        // Each write state spends its first cycle with memReq low, guaranteeing the gap between words.
        WR1: begin
          if (ackHit) begin
            memReq        <= 1'b0;
            memWriteDone1 <= 1'b1;
            if (!doubleQ) memWriteDone2 <= 1'b1;
            addrQ         <= addrQ + ADDR_W'(ADDR_STEP);
          end else if (expired) begin
            memReq      <= 1'b0;
            memWriteErr <= 1'b1;
          end else if (!memReq) begin
            memReq   <= 1'b1;
            memAddr  <= addrQ;
            memWData <= data1Q;
          end
        end
        WR2: begin
          if (ackHit) begin
            memReq        <= 1'b0;
            memWriteDone2 <= 1'b1;
          end else if (expired) begin
            memReq      <= 1'b0;
            memWriteErr <= 1'b1;
          end else if (!memReq) begin
            memReq   <= 1'b1;
            memAddr  <= addrQ;
            memWData <= data2Q;
          end
        end
        DONE, ERR: begin
          if (instrClear) begin
            memWriteDone1 <= 1'b0;
            memWriteDone2 <= 1'b0;
            memWriteErr   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEMWR_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      $display("[memwr] reset");
    end else begin
      if (ackHit && (state == WR1 || state == WR2))
        $display("[memwr] write addr=%h data=%h", memAddr, memWData);
      if (expired && (state == WR1 || state == WR2))
        $display("[memwr] ack timeout addr=%h", memAddr);
      if (instrClear && (state == DONE || state == ERR))
        $display("[memwr] instrClear");
    end
  end
`else
`endif

endmodule

// File: tb/tb_mem_write_ctrl.sv
// tb/tb_mem_write_ctrl.sv - scoreboard bench for mem_write_ctrl with randomized stores and ack latencies
module tb_mem_write_ctrl;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int STEP = 4;
  localparam int MW   = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          storeValid = 1'b0;
  logic          storeReady;
  logic          storeDouble = 1'b0;
  logic [AW-1:0] storeAddr = '0;
  logic [DW-1:0] storeData1 = '0;
  logic [DW-1:0] storeData2 = '0;
  logic          noStore = 1'b0;
  logic          instrClear = 1'b0;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWData;
  logic          memAck;
  logic          memWriteDone1;
  logic          memWriteDone2;
  logic          memWriteErr;

  always #5 clk = ~clk;

  mem_write_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ADDR_STEP(STEP), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .storeValid(storeValid), .storeReady(storeReady),
    .storeDouble(storeDouble), .storeAddr(storeAddr), .storeData1(storeData1),
    .storeData2(storeData2), .noStore(noStore), .instrClear(instrClear),
    .memReq(memReq), .memAddr(memAddr), .memWData(memWData), .memAck(memAck),
    .memWriteDone1(memWriteDone1), .memWriteDone2(memWriteDone2), .memWriteErr(memWriteErr)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t expQ[$];
  int  latQ[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: acks on the Nth cycle of each request, N taken from latQ (0 = never).
  initial begin
    int reqCnt;
    int curLat;
    reqCnt = 0;
    curLat = 0;
    memAck = 1'b0;
    forever begin
      @(negedge clk);
      if (memAck) begin
        memAck = 1'b0;
        reqCnt = 0;
      end else if (memReq) begin
        if (reqCnt == 0) begin
          curLat = 0;
          if (latQ.size() > 0) curLat = latQ.pop_front();
        end
        reqCnt++;
        if (reqCnt == curLat) memAck = 1'b1;
      end else begin
        reqCnt = 0;
      end
    end
  end

  // Scoreboard monitor: every accepted write is compared against the expected queue.
  initial begin
    logic prevAck;
    wr_t  e;
    prevAck = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (prevAck) check("req_gap", memReq, 0);
      prevAck = memReq && memAck;
      if (memReq && memAck) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %h@%h required none", memWData, memAddr);
        end else begin
          e = expQ.pop_front();
          check("wr_addr", memAddr, e.a);
          check("wr_data", memWData, e.d);
        end
      end
    end
  end

  task automatic waitReady();
    int n;
    n = 0;
    while (!storeReady && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("ready_wait", storeReady, 1);
  endtask

  task automatic clearInstr();
    @(negedge clk);
    instrClear = 1'b1;
    @(negedge clk);
    instrClear = 1'b0;
    #1;
    check("clr_done1", memWriteDone1, 0);
    check("clr_done2", memWriteDone2, 0);
    check("clr_err", memWriteErr, 0);
    check("clr_ready", storeReady, 1);
    expQ.delete();
    latQ.delete();
  endtask

  task automatic runStore(input bit dbl, input logic [AW-1:0] addr, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input int l1, input int l2,
                          input bit withNo, input bit clrMid);
    bit ok1, ok2, expD1, expD2, expErr;
    int expCyc, doneCyc, d1Cyc;
    wr_t w;
    ok1 = (l1 >= 1) && (l1 <= MW);
    ok2 = (l2 >= 1) && (l2 <= MW);
    latQ.delete();
    latQ.push_back(l1);
    if (dbl) latQ.push_back(l2);
    w.a = addr; w.d = d1;
    if (ok1) expQ.push_back(w);
    w.a = addr + AW'(STEP); w.d = d2;
    if (dbl && ok1 && ok2) expQ.push_back(w);
    expD1  = ok1;
    expD2  = dbl ? (ok1 && ok2) : ok1;
    expErr = !expD2;
    if (!ok1)      expCyc = 2 + MW;
    else if (!dbl) expCyc = 2 + l1;
    else if (!ok2) expCyc = 3 + l1 + MW;
    else           expCyc = 3 + l1 + l2;

    waitReady();
    @(negedge clk);
    storeValid = 1'b1; storeDouble = dbl; storeAddr = addr;
    storeData1 = d1; storeData2 = d2; noStore = withNo;
    @(negedge clk);
    storeValid = 1'b0; noStore = 1'b0;
    doneCyc = 0;
    d1Cyc = 0;
    for (int k = 1; k <= 60 && doneCyc == 0; k++) begin
      if (k > 1) @(negedge clk);
      instrClear = clrMid && (k == 2);
      storeValid = (k == 3);
      storeAddr  = 32'h0000_BAD0;
      storeData1 = 32'hBADBAD01;
      #1;
      if (memWriteDone1 && d1Cyc == 0) d1Cyc = k;
      if ((memWriteDone1 && memWriteDone2) || memWriteErr) doneCyc = k;
    end
    instrClear = 1'b0;
    storeValid = 1'b0;
    check("settle_cycle", doneCyc, expCyc);
    check("done1", memWriteDone1, expD1);
    check("done2", memWriteDone2, expD2);
    check("err", memWriteErr, expErr);
    check("req_low", memReq, 0);
    if (dbl && expD2) check("done1_first", d1Cyc, 2 + l1);
    check("writes_left", expQ.size(), 0);
    repeat (2) @(negedge clk);
    #1;
    check("hold_done1", memWriteDone1, expD1);
    check("hold_done2", memWriteDone2, expD2);
    clearInstr();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", memReq, 0);
    check("rst_ready", storeReady, 0);
    check("rst_done1", memWriteDone1, 0);
    check("rst_done2", memWriteDone2, 0);
    check("rst_err", memWriteErr, 0);
    check("rst_addr", memAddr, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_ready_after", storeReady, 1);

    runStore(1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0, 1'b0, 1'b0);
    runStore(1'b1, 32'hFFFF_FFFC, 32'h11, 32'h22, 1, 1, 1'b0, 1'b0);
    runStore(1'b0, 32'h200, 32'h12345678, 32'h0, 1, 0, 1'b0, 1'b0);
    runStore(1'b0, 32'h300, 32'hCAFEF00D, 32'h0, 0, 0, 1'b0, 1'b0);
    runStore(1'b0, 32'h304, 32'hA5A5A5A5, 32'h0, MW, 0, 1'b0, 1'b0);
    runStore(1'b1, 32'h400, 32'h1, 32'h2, 3, MW + 1, 1'b0, 1'b0);
    runStore(1'b0, 32'h500, 32'h55AA55AA, 32'h0, 2, 0, 1'b1, 1'b1);

    // noStore alone: both dones next cycle, no memory request
    waitReady();
    @(negedge clk);
    noStore = 1'b1;
    @(negedge clk);
    noStore = 1'b0;
    #1;
    check("nostore_done1", memWriteDone1, 1);
    check("nostore_done2", memWriteDone2, 1);
    check("nostore_req", memReq, 0);
    check("nostore_ready", storeReady, 0);
    clearInstr();

    // Reset while a write request is outstanding
    waitReady();
    latQ.delete();
    latQ.push_back(0);
    @(negedge clk);
    storeValid = 1'b1; storeDouble = 1'b1; storeAddr = 32'h600;
    @(negedge clk);
    storeValid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_req_high", memReq, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_req", memReq, 0);
    check("mid_rst_done1", memWriteDone1, 0);
    check("mid_rst_done2", memWriteDone2, 0);
    check("mid_rst_err", memWriteErr, 0);
    check("mid_rst_ready", storeReady, 0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_ready_after", storeReady, 1);
    latQ.delete();
    expQ.delete();

    for (int i = 0; i < 25; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      runStore(1'($urandom_range(0, 1)), a, $urandom(), $urandom(),
               $urandom_range(1, MW + 2), $urandom_range(1, MW + 2),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
